keypad_scan: RTL and testbench
==============================

# keypad_scan

Column-scanning controller for the 4x4 matrix keypad. It drives one keypad column high at a time and consumes `stop_flag`/`row_code` from the combinational row detector sitting on the keypad row lines. It debounces presses and releases, then emits a 4-bit key code with a one-cycle valid strobe to downstream logic (display/arithmetic stages).

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven while scanning; minimum 4.
- `DEBOUNCE_CYCLES`, default 10000: consecutive stable synchronized cycles required to accept a press or a release; minimum 2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset. Single clock domain; reset asserts asynchronously and is released synchronously by the top level.
- `stop_flag`  in  1  row detector reports exactly one row high; asynchronous to `clk`.
- `row_code`  in  2  encoded active row. Valid only while `stop_flag`=1; may be Z otherwise.
- `col`  out  4  one-hot column drive to the keypad.
- `key_code`  out  4  accepted key, `{row_code, col_idx}` (row*4 + col).
- `key_valid`  out  1  one-cycle pulse when a debounced press is accepted.
- `key_held`  out  1  high from acceptance until the release is debounced.

## Operation
- Input conditioning:
  - `stop_flag` and `row_code` pass through a 2-flop synchronizer (3 bits) before any use.
  - While `stop_flag_s`=0, `row_code_s` is treated as don't-care; Z/X on it must not propagate into state.
- States: SCAN, DEBOUNCE, PRESSED, RELEASE.
- Reset values:
  - state SCAN, `col_idx`=0, `col`=4'b0001.
  - `key_code`=0, `key_valid`=0, `key_held`=0, all counters 0, synchronizers 0.
- SCAN:
  - `tick_cnt` counts 0..SCAN_DIV-1.
  - `stop_flag_s` is ignored while `tick_cnt`<3 (settle window after a column change).
  - If `stop_flag_s`=1 with `tick_cnt`>=3: freeze `col`, latch `cand_row`<=`row_code_s`, set `db_cnt`<=0, go to DEBOUNCE.
  - Else, at `tick_cnt`=SCAN_DIV-1: `col_idx`++ (wraps 3->0), `col` rotates left (4'b1000 -> 4'b0001), `tick_cnt`<=0.
- DEBOUNCE:
  - If `stop_flag_s`=1 and `row_code_s`=`cand_row`:
    - when `db_cnt`=DEBOUNCE_CYCLES-1: go to PRESSED, `key_code`<={`cand_row`,`col_idx`}, `key_valid`<=1, `key_held`<=1;
    - otherwise `db_cnt`++.
  - Else (flag dropped or row changed): return to SCAN with `tick_cnt`<=0 on the same column, no advance, no output.
- PRESSED:
  - `col` stays frozen.
  - `stop_flag_s`=0 -> go to RELEASE, `db_cnt`<=0.
  - A change of `row_code_s` while the flag is 1 is ignored (no second key; two-key rollover is not supported).
- RELEASE:
  - If `stop_flag_s`=0: when `db_cnt`=DEBOUNCE_CYCLES-1, set `key_held`<=0, advance column as in SCAN, `tick_cnt`<=0, go to SCAN; otherwise `db_cnt`++.
  - If `stop_flag_s`=1: return to PRESSED with no new `key_valid` (release bounce).
- `key_code` holds its last accepted value until the next acceptance.
- Reset asserted in any state returns all registers to reset values immediately; a partially debounced key is discarded.

## Timing
- All outputs are registered; `col` changes only on a `clk` edge.
- Press-to-`key_valid` latency:
  - 2 cycles of synchronizer, plus 1 edge to enter DEBOUNCE, plus DEBOUNCE_CYCLES edges.
  - Measured from the first raw `stop_flag`=1 sampled in a valid window: DEBOUNCE_CYCLES+3 edges.
- `key_valid` is high for exactly one cycle per accepted press. It is never asserted in RELEASE, or when returning from RELEASE to PRESSED.
- Release-to-`key_held`=0: DEBOUNCE_CYCLES+3 edges after raw `stop_flag` falls, provided it stays low.
- Full scan period with no key pressed: 4*SCAN_DIV cycles.
- If a press arrives at `tick_cnt`=SCAN_DIV-1 (simultaneous with the column advance), the press takes priority and the column does not advance.

## Structure
- `keypad_pkg`:
  - `typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} scan_state_t`;
  - `COL_RESET` = 4'b0001;
  - `SETTLE_CYCLES` = 3;
  - width helper for `$clog2` counter sizing.
- Sub-module `sync_2ff` (parameterized width): used for the 3-bit `{stop_flag, row_code}` input.
- Top-level wiring of `keypad_scan` to the row detector lives in the integration module, not here.

## Test plan
Parameters for all cases: SCAN_DIV=8, DEBOUNCE_CYCLES=4.
- Reset, idle:
  - Stimulus: hold `rst_n`=0, release, no key pressed.
  - Required: `col` = 0001, 0010, 0100, 1000, 0001, changing every 8 cycles; `key_valid`=0 throughout.
- Clean press of row 2 while `col`=0100:
  - Stimulus: hold the row during scan.
  - Required: `key_valid` pulses once 7 edges after the flag is first sampled; `key_code`=4'b1010; `key_held`=1; `col` frozen at 0100.
- Bounce during press:
  - Stimulus: `stop_flag` toggles 1,0,1 with periods shorter than 4 cycles, then holds stable.
  - Required: no `key_valid` until the stable period completes, then exactly one pulse.
- Release bounce:
  - Stimulus: after acceptance, `stop_flag` drops for 2 cycles, returns for 5, then drops for good.
  - Required: `key_held` stays 1 through the glitch; no extra `key_valid`; `key_held` falls 7 edges after the final drop; `col` then advances to 1000.
- Row change in DEBOUNCE:
  - Stimulus: `row_code` changes 01 -> 11 mid-debounce.
  - Required: FSM returns to SCAN on the same column, then accepts row 3 on re-detect.
- Reset mid-PRESSED:
  - Stimulus: assert `rst_n`=0 asynchronously.
  - Required: `col`=0001, `key_held`=0, `key_code`=0 without waiting for a clock edge.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the 4x4 keypad column scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } scan_state_t;

    localparam logic [3:0] COL_RESET = 4'b0001;
    localparam int SETTLE_CYCLES = 3;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad-side lines and downstream key outputs of the scanner.
interface keypad_scan_if;

    logic       stop_flag;
    logic [1:0] row_code;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  stop_flag,
        input  row_code,
        output col,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output stop_flag,
        output row_code,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/keypad_scan_sync.sv
// Two-flop synchronizer for asynchronous inputs, reset to zero.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// Column-scanning keypad controller with press/release debounce.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic          clk,
    input  logic          rst_n,
    keypad_scan_if.master kp
);

    localparam int TW = cnt_w(SCAN_DIV);
    localparam int DW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] SETTLE    = TW'(SETTLE_CYCLES);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    logic [2:0]  sync_q;
    logic        flag_s;
    logic [1:0]  row_s;

    scan_state_t state, state_n;
    logic [TW-1:0] tick_cnt, tick_n;
    logic [DW-1:0] db_cnt, db_n;
    logic [1:0]  col_idx, idx_n;
    logic [3:0]  col, col_n;
    logic [1:0]  cand_row, cand_n;
    logic [3:0]  key_code, code_n;
    logic        key_valid, valid_n;
    logic        key_held, held_n;

    sync_2ff #(.WIDTH(3)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({kp.stop_flag, kp.row_code}),
        .q     (sync_q)
    );

    assign flag_s = sync_q[2];
    assign row_s  = sync_q[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            tick_cnt  <= '0;
            db_cnt    <= '0;
            col_idx   <= '0;
            col       <= COL_RESET;
            cand_row  <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_n;
            db_cnt    <= db_n;
            col_idx   <= idx_n;
            col       <= col_n;
            cand_row  <= cand_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end

    // row_s is only read while flag_s is high, so a floating row bus never reaches state
    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        db_n    = db_cnt;
        idx_n   = col_idx;
        col_n   = col;
        cand_n  = cand_row;
        code_n  = key_code;
        valid_n = 1'b0;
        held_n  = key_held;
        unique case (state)
            SCAN: begin
                if (flag_s && tick_cnt >= SETTLE) begin
                    state_n = DEBOUNCE;
                    cand_n  = row_s;
                    db_n    = '0;
                end else if (tick_cnt == TICK_LAST) begin
                    idx_n  = col_idx + 2'd1;
                    col_n  = {col[2:0], col[3]};
                    tick_n = '0;
                end else begin
                    tick_n = tick_cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (flag_s && row_s == cand_row) begin
                    if (db_cnt == DB_LAST) begin
                        state_n = PRESSED;
                        code_n  = {cand_row, col_idx};
                        valid_n = 1'b1;
                        held_n  = 1'b1;
                    end else begin
                        db_n = db_cnt + 1'b1;
                    end
                end else begin
                    state_n = SCAN;
                    tick_n  = '0;
                end
            end
            PRESSED: begin
                if (!flag_s) begin
                    state_n = RELEASE;
                    db_n    = '0;
                end
            end
            RELEASE: begin
                if (flag_s) begin
                    state_n = PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    state_n = SCAN;
                    held_n  = 1'b0;
                    idx_n   = col_idx + 2'd1;
                    col_n   = {col[2:0], col[3]};
                    tick_n  = '0;
                end else begin
                    db_n = db_cnt + 1'b1;
                end
            end
        endcase
    end

    assign kp.col       = col;
    assign kp.key_code  = key_code;
    assign kp.key_valid = key_valid;
    assign kp.key_held  = key_held;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan with SCAN_DIV=8, DEBOUNCE_CYCLES=4.
module tb_keypad_scan;

    localparam int SD = 8;
    localparam int DC = 4;

    typedef struct {
        logic [3:0] code;
        int         cyc;
        logic [3:0] col;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    keypad_scan_if kp ();

    keypad_scan #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (cycle %0d)",
                      name, act, req, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_col(input logic [3:0] t);
        int k = 0;
        while (kp.col !== t && k < 64) begin
            @(negedge clk);
            k++;
        end
        check("wait_col", int'(kp.col), int'(t));
    endtask

    task automatic release_clean(input logic [3:0] nxt);
        int c;
        step();
        kp.stop_flag = 1'b0;
        c = cyc;
        at_cyc(c + 6);
        check("held_before_release", int'(kp.key_held), 1);
        at_cyc(c + 7);
        check("held_after_release", int'(kp.key_held), 0);
        check("col_after_release", int'(kp.col), int'(nxt));
    endtask

    // Scoreboard monitor: every key_valid must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && kp.key_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_key_valid", int'(kp.key_valid), 0);
            end else begin
                e = sb.pop_front();
                check("key_code", int'(kp.key_code), int'(e.code));
                check("valid_cycle", cyc, e.cyc);
                check("col_frozen", int'(kp.col), int'(e.col));
                check("held_at_valid", int'(kp.key_held), 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] seq [5];
        int vals [4];
        int durs [4];
        int r;
        int c;
        seq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        vals = '{1, 0, 1, 0};
        durs = '{2, 1, 3, 2};

        rst_n = 1'b0;
        kp.stop_flag = 1'b0;
        kp.row_code = 2'b00;
        repeat (3) @(posedge clk);
        #2;
        check("rst_col", int'(kp.col), 1);
        check("rst_code", int'(kp.key_code), 0);
        check("rst_valid", int'(kp.key_valid), 0);
        check("rst_held", int'(kp.key_held), 0);

        rst_n = 1'b1;
        r = cyc;
        for (int k = 1; k <= 4; k++) begin
            at_cyc(r + SD * k - 1);
            check("idle_col_hold", int'(kp.col), int'(seq[k-1]));
            at_cyc(r + SD * k);
            check("idle_col_step", int'(kp.col), int'(seq[k]));
        end

        // clean press row 2 on column 2, then release with bounce
        wait_col(4'b0100);
        step();
        step();
        kp.row_code = 2'd2;
        kp.stop_flag = 1'b1;
        c = cyc;
        sb.push_back('{code: 4'b1010, cyc: c + 7, col: 4'b0100});
        at_cyc(c + 9);
        check("press_held", int'(kp.key_held), 1);
        check("press_col", int'(kp.col), 4'b0100);

        step();
        kp.stop_flag = 1'b0;
        step();
        step();
        kp.stop_flag = 1'b1;
        repeat (5) step();
        check("glitch_held", int'(kp.key_held), 1);
        kp.stop_flag = 1'b0;
        c = cyc;
        at_cyc(c + 6);
        check("rel_bounce_held", int'(kp.key_held), 1);
        at_cyc(c + 7);
        check("rel_bounce_drop", int'(kp.key_held), 0);
        check("rel_bounce_col", int'(kp.col), 4'b1000);

        // bouncing press of row 1 on column 0
        wait_col(4'b0001);
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            kp.stop_flag = vals[i][0];
            kp.row_code = vals[i][0] ? 2'd1 : 2'd0;
            repeat (durs[i]) step();
        end
        kp.stop_flag = 1'b1;
        kp.row_code = 2'd1;
        c = cyc;
        sb.push_back('{code: 4'b0100, cyc: c + 7, col: 4'b0001});
        at_cyc(c + 9);
        check("bounce_held", int'(kp.key_held), 1);
        release_clean(4'b0010);

        // row changes 01 -> 11 mid-debounce on column 1
        wait_col(4'b0010);
        step();
        step();
        kp.row_code = 2'd1;
        kp.stop_flag = 1'b1;
        c = cyc;
        repeat (3) step();
        kp.row_code = 2'd3;
        sb.push_back('{code: 4'b1101, cyc: c + 14, col: 4'b0010});
        at_cyc(c + 16);
        check("rowchg_held", int'(kp.key_held), 1);
        check("rowchg_code", int'(kp.key_code), 4'b1101);
        release_clean(4'b0100);

        // asynchronous reset while PRESSED
        wait_col(4'b0100);
        step();
        step();
        kp.row_code = 2'd0;
        kp.stop_flag = 1'b1;
        c = cyc;
        sb.push_back('{code: 4'b0010, cyc: c + 7, col: 4'b0100});
        at_cyc(c + 10);
        check("pre_rst_held", int'(kp.key_held), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_col", int'(kp.col), 1);
        check("async_rst_held", int'(kp.key_held), 0);
        check("async_rst_code", int'(kp.key_code), 0);
        check("async_rst_valid", int'(kp.key_valid), 0);
        kp.stop_flag = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_col", int'(kp.col), 1);
        check("post_rst_held", int'(kp.key_held), 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
